// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg -- shared constants and types for the SPI-configured PWM
// register block.
//   * register addresses and CTRL/STATUS bit positions
//   * reset values of the active/shadow registers (width-independent bits)
//   * SPI frame FSM state encoding
//   * cfg_wr_t: one decoded write frame handed from the SPI FSM to the
//     register file
package pwm_cfg_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int BYTE_W  = 8;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_DUTY   = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 7'h03;

   localparam int CTRL_EN_BIT       = 0;
   localparam int CTRL_FORCE_BIT    = 1;
   localparam int STAT_PENDING_BIT  = 0;
   localparam int STAT_FRAME_ERR_BIT = 1;

   // Replicated across DATA_W in the top: period resets to all-ones,
   // duty to zero.
   localparam logic RST_PERIOD_BIT = 1'b1;
   localparam logic RST_DUTY_BIT   = 1'b0;

   typedef logic [2:0] spi_state_t;
   localparam spi_state_t ST_IDLE = 3'd0;
   localparam spi_state_t ST_CMD  = 3'd1;
   localparam spi_state_t ST_DATA = 3'd2;
   localparam spi_state_t ST_DONE = 3'd3;
   localparam spi_state_t ST_ERR  = 3'd4;

   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] addr;
      logic [BYTE_W-1:0] data;
   } cfg_wr_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge -- multi-flop synchronizer for an asynchronous input with
// single-cycle rise/fall pulses on the synchronized level.
//   clk, rst : clock, synchronous active-high reset
//   din      : asynchronous input
//   rise     : one-clk pulse on a synchronized 0->1 transition
//   fall     : one-clk pulse on a synchronized 1->0 transition
// RST_VAL sets the value the chain holds during reset. A chain reset to 0
// only produces a falling edge after a real high has propagated through.
module pwm_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain[0] <= din;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prev <= chain[STAGES-1];
      end
   end

   assign rise =  chain[STAGES-1] & ~prev;
   assign fall = ~chain[STAGES-1] &  prev;

endmodule

// File: rtl/pwm_cfg_spi.sv
// pwm_cfg_spi -- SPI (mode 0) slave holding PWM period/duty configuration.
// 16-bit frames: bit15 write(1)/read(0), bits14:8 address, bits7:0 data.
// Writes land in shadow registers; the shadow is copied to the active
// registers on period_end when pending, immediately while the PWM is
// disabled, or immediately on a CTRL force_update write.
//   clk, rst     : clock, synchronous active-high reset
//   spi_sck      : SPI clock (async, <= clk/4)
//   spi_cs_n     : frame select, active low (async)
//   spi_mosi     : serial data in, MSB first (async)
//   period_end   : one-clk pulse from the PWM core at each period end
//   spi_miso     : readback data
//   spi_miso_oe  : MISO pad enable
//   pwm_period   : active period
//   pwm_duty     : active duty, clamped to the active period
//   pwm_en       : PWM enable (CTRL bit0)
//   cfg_pending  : shadow differs from active
// Build option: PWM_CFG_READBACK_EN enables register readback on MISO;
// without it MISO is held low and read frames are silently accepted.
module pwm_cfg_spi
   import pwm_cfg_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   input  logic              period_end,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [DATA_W-1:0] pwm_period,
   output logic [DATA_W-1:0] pwm_duty,
   output logic              pwm_en,
   output logic              cfg_pending
);

   // ---------------------------------------------------------------- sync
   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic mosi_s;

   pwm_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk (clk), .rst (rst), .din (spi_sck),
      .rise(sck_rise), .fall(sck_fall)
   );

   // cs_n chain resets low: a frame already running at reset release
   // yields no falling edge until cs_n has been seen high.
   pwm_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
      .clk (clk), .rst (rst), .din (spi_cs_n),
      .rise(cs_rise), .fall(cs_fall)
   );

   // Same depth as the sck chain, so mosi_s lines up with sck_rise.
   always_ff @(posedge clk) begin
      if (rst) mosi_q <= '0;
      else begin
         mosi_q[0] <= spi_mosi;
         for (int i = 1; i < SYNC_STAGES; i++) mosi_q[i] <= mosi_q[i-1];
      end
   end
   assign mosi_s = mosi_q[SYNC_STAGES-1];

   // ----------------------------------------------------------- frame FSM
   spi_state_t           state;
   logic [3:0]           bit_cnt;
   logic [FRAME_W-1:0]   rx_sr;
   logic                 frame_err;
   cfg_wr_t              wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         frame_err <= 1'b0;
         wr        <= '0;
      end else begin
         wr.vld <= 1'b0;
         // Clear first so a discard in the same cycle still sets the flag.
         if (wr.vld && wr.addr == ADDR_STATUS && wr.data[STAT_FRAME_ERR_BIT])
            frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  state   <= ST_CMD;
                  bit_cnt <= '0;
               end
            end
            ST_CMD, ST_DATA: begin
               if (cs_rise) begin
                  state     <= ST_IDLE;
                  frame_err <= 1'b1;
               end else if (sck_rise) begin
                  rx_sr   <= {rx_sr[FRAME_W-2:0], mosi_s};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (state == ST_CMD  && bit_cnt == 4'd7)  state <= ST_DATA;
                  if (state == ST_DATA && bit_cnt == 4'd15) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (cs_rise) begin
                  state   <= ST_IDLE;
                  wr.vld  <= rx_sr[FRAME_W-1];
                  wr.addr <= rx_sr[FRAME_W-2:BYTE_W];
                  wr.data <= rx_sr[BYTE_W-1:0];
               end else if (sck_rise) begin
                  state <= ST_ERR;
               end
            end
            ST_ERR: begin
               if (cs_rise) begin
                  state     <= ST_IDLE;
                  frame_err <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------ register file
   logic [DATA_W-1:0] period_sh, duty_sh, period_act, duty_act;
   logic [DATA_W-1:0] period_sh_nxt, duty_sh_nxt;
   logic              force_upd;
   logic              en_q;

   always_comb begin
      period_sh_nxt = period_sh;
      duty_sh_nxt   = duty_sh;
      if (wr.vld && wr.addr == ADDR_PERIOD) period_sh_nxt = DATA_W'(wr.data);
      if (wr.vld && wr.addr == ADDR_DUTY)   duty_sh_nxt   = DATA_W'(wr.data);
   end

   assign force_upd = wr.vld && wr.addr == ADDR_CTRL && wr.data[CTRL_FORCE_BIT];

   always_ff @(posedge clk) begin
      if (rst) begin
         period_sh  <= {DATA_W{RST_PERIOD_BIT}};
         duty_sh    <= {DATA_W{RST_DUTY_BIT}};
         period_act <= {DATA_W{RST_PERIOD_BIT}};
         duty_act   <= {DATA_W{RST_DUTY_BIT}};
         en_q       <= 1'b0;
      end else begin
         period_sh <= period_sh_nxt;
         duty_sh   <= duty_sh_nxt;
         if (wr.vld && wr.addr == ADDR_CTRL) en_q <= wr.data[CTRL_EN_BIT];
         if (!en_q || force_upd) begin
            // Disabled: write straight through so cfg_pending never blips.
            period_act <= period_sh_nxt;
            duty_act   <= duty_sh_nxt;
         end else if (period_end && cfg_pending) begin
            // Pre-write shadow; a coincident write stays pending.
            period_act <= period_sh;
            duty_act   <= duty_sh;
         end
      end
   end

   assign cfg_pending = (period_sh != period_act) || (duty_sh != duty_act);
   assign pwm_en      = en_q;
   assign pwm_period  = period_act;
   assign pwm_duty    = (duty_act > period_act) ? period_act : duty_act;

   // ------------------------------------------------------------ readback
`ifdef PWM_CFG_READBACK_EN
   logic [BYTE_W-1:0] rd_data, tx_sr;
   logic [ADDR_W-1:0] rd_addr;

   // Address is complete on the 8th rising edge: last bit still in mosi_s.
   assign rd_addr = {rx_sr[ADDR_W-2:0], mosi_s};

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         ADDR_CTRL:   rd_data[CTRL_EN_BIT] = en_q;
         ADDR_PERIOD: rd_data = BYTE_W'(period_sh);
         ADDR_DUTY:   rd_data = BYTE_W'(duty_sh);
         ADDR_STATUS: begin
            rd_data[STAT_PENDING_BIT]   = cfg_pending;
            rd_data[STAT_FRAME_ERR_BIT] = frame_err;
         end
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sr    <= '0;
         spi_miso <= 1'b0;
      end else if (state == ST_CMD && sck_rise && !cs_rise && bit_cnt == 4'd7) begin
         tx_sr <= rd_data;
      end else if (state == ST_DATA && sck_fall) begin
         spi_miso <= tx_sr[BYTE_W-1];
         tx_sr    <= {tx_sr[BYTE_W-2:0], 1'b0};
      end else if (state == ST_IDLE) begin
         spi_miso <= 1'b0;
      end
   end

   assign spi_miso_oe = (state != ST_IDLE);
`else
   // sck falling edges and frame_err only feed the readback path.
   logic unused_rb;
   assign unused_rb   = ^{sck_fall, frame_err};
   assign spi_miso    = 1'b0;
   assign spi_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_cfg_spi.sv
// tb_pwm_cfg_spi -- directed bench for pwm_cfg_spi. Define
// PWM_CFG_READBACK_EN to include the MISO readback checks.
module tb_pwm_cfg_spi;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
   logic          period_end = 1'b0;
   logic          spi_miso, spi_miso_oe, pwm_en, cfg_pending;
   logic [DW-1:0] pwm_period, pwm_duty;

   int   nvec = 0, nerr = 0;
   logic seen_drive = 1'b0;
   logic [15:0] rb;

   pwm_cfg_spi #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .period_end(period_end), .spi_miso(spi_miso),
      .spi_miso_oe(spi_miso_oe), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
      .pwm_en(pwm_en), .cfg_pending(cfg_pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Clocks n bits (MSB first) with cs_n low; sck half period = 4 clk.
   // MISO is sampled just before each rising sck edge.
   task automatic spi_bits(input logic [15:0] w, input int n, output logic [15:0] r);
      r = '0;
      spi_cs_n = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < n; i++) begin
         spi_mosi = (i < 16) ? w[15-i] : 1'b0;
         repeat (4) tick();
         if (i < 16) r[15-i] = spi_miso;
         if (spi_miso_oe || spi_miso) seen_drive = 1'b1;
         spi_sck = 1'b1;
         repeat (4) tick();
         spi_sck = 1'b0;
      end
      repeat (4) tick();
   endtask

   task automatic spi_xfer(input logic [15:0] w, input int n, output logic [15:0] r);
      spi_bits(w, n, r);
      spi_cs_n = 1'b1;
      repeat (8) tick();
   endtask

   task automatic pulse_period_end();
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("rst_period", 16'(pwm_period), 16'h00FF);
      chk("rst_duty", 16'(pwm_duty), 16'h0000);
      chk("rst_en", 16'(pwm_en), 16'h0);
      chk("rst_pending", 16'(cfg_pending), 16'h0);
      chk("rst_miso", 16'(spi_miso), 16'h0);
      chk("rst_miso_oe", 16'(spi_miso_oe), 16'h0);

      // PERIOD=0x64 while disabled: active within 4 clk, never pending
      spi_bits(16'h8164, 16, rb);
      spi_cs_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("dis_wr_pending", 16'(cfg_pending), 16'h0);
      end
      chk("dis_wr_period", 16'(pwm_period), 16'h0064);

      // enable
      spi_xfer(16'h8001, 16, rb);
      chk("en_set", 16'(pwm_en), 16'h1);
      chk("en_pending", 16'(cfg_pending), 16'h0);

      // DUTY=0x20 while enabled: held until period_end
      spi_xfer(16'h8220, 16, rb);
      chk("duty_pending", 16'(cfg_pending), 16'h1);
      chk("duty_held", 16'(pwm_duty), 16'h0000);
      repeat (5) tick();
      chk("duty_still_held", 16'(pwm_duty), 16'h0000);
      pulse_period_end();
      chk("duty_commit", 16'(pwm_duty), 16'h0020);
      chk("duty_commit_pending", 16'(cfg_pending), 16'h0);

      // period_end coincident with a shadow write
      spi_xfer(16'h8230, 16, rb);
      chk("coin_pre_pending", 16'(cfg_pending), 16'h1);
      spi_bits(16'h8240, 16, rb);
      spi_cs_n = 1'b1;
      repeat (3) tick();
      pulse_period_end();
      chk("coin_old_commit", 16'(pwm_duty), 16'h0030);
      chk("coin_still_pending", 16'(cfg_pending), 16'h1);
      repeat (3) tick();
      chk("coin_hold", 16'(pwm_duty), 16'h0030);
      pulse_period_end();
      chk("coin_new_commit", 16'(pwm_duty), 16'h0040);
      chk("coin_pending_clr", 16'(cfg_pending), 16'h0);

      // 15-bit frame discarded
      spi_xfer(16'h8133, 15, rb);
      chk("short_period", 16'(pwm_period), 16'h0064);
      chk("short_pending", 16'(cfg_pending), 16'h0);
      // 17-bit frame: extra edge after the 16th bit discards it
      spi_xfer(16'h8177, 17, rb);
      chk("long_period", 16'(pwm_period), 16'h0064);
      chk("long_pending", 16'(cfg_pending), 16'h0);
      // read frame has no effect on registers
      spi_xfer(16'h0100, 16, rb);
      chk("read_period", 16'(pwm_period), 16'h0064);
      chk("read_pending", 16'(cfg_pending), 16'h0);
`ifdef PWM_CFG_READBACK_EN
      spi_xfer(16'h0300, 16, rb);
      chk("status_err", 16'(rb[7:0]), 16'h0002);
      spi_xfer(16'h8302, 16, rb);
      spi_xfer(16'h0300, 16, rb);
      chk("status_clr", 16'(rb[7:0]), 16'h0000);
`endif

      // clamp, disabled so writes are immediate
      spi_xfer(16'h8000, 16, rb);
      chk("dis_en", 16'(pwm_en), 16'h0);
      spi_xfer(16'h8110, 16, rb);
      spi_xfer(16'h8230, 16, rb);
      chk("clamp_period", 16'(pwm_period), 16'h0010);
      chk("clamp_duty", 16'(pwm_duty), 16'h0010);
      spi_xfer(16'h8100, 16, rb);
      chk("zero_period", 16'(pwm_period), 16'h0000);
      chk("zero_duty", 16'(pwm_duty), 16'h0000);
      spi_xfer(16'h8180, 16, rb);
      chk("unclamp_duty", 16'(pwm_duty), 16'h0030);

      // force_update while enabled
      spi_xfer(16'h8001, 16, rb);
      spi_xfer(16'h8205, 16, rb);
      chk("force_pre_pending", 16'(cfg_pending), 16'h1);
      chk("force_pre_duty", 16'(pwm_duty), 16'h0030);
      spi_xfer(16'h8003, 16, rb);
      chk("force_duty", 16'(pwm_duty), 16'h0005);
      chk("force_pending", 16'(cfg_pending), 16'h0);
      chk("force_en", 16'(pwm_en), 16'h1);

`ifdef PWM_CFG_READBACK_EN
      spi_xfer(16'h81A5, 16, rb);
      spi_xfer(16'h0100, 16, rb);
      chk("rb_period", 16'(rb[7:0]), 16'h00A5);
      chk("rb_oe_seen", 16'(seen_drive), 16'h1);
`else
      chk("no_miso_drive", 16'(seen_drive), 16'h0);
`endif

      // reset in the middle of a frame: that frame must be ignored
      rst = 1'b1;
      spi_cs_n = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      spi_xfer(16'h8111, 16, rb);
      chk("midrst_period", 16'(pwm_period), 16'h00FF);
      chk("midrst_pending", 16'(cfg_pending), 16'h0);
      chk("midrst_en", 16'(pwm_en), 16'h0);
      spi_xfer(16'h8122, 16, rb);
      chk("post_rst_write", 16'(pwm_period), 16'h0022);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pwm_cfg_spi.md
PWM_CFG_SPI -- requirements
Module: pwm_cfg_spi

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, width of period/duty registers.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, input synchronizer depth.
REQ-003 SHALL have ports: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: spi_sck  input  1  SPI clock, mode 0, async to clk, max clk/4.
REQ-006 SHALL have ports: spi_cs_n  input  1  frame select, active-low, async.
REQ-007 SHALL have ports: spi_mosi  input  1  serial data in, MSB first, async.
REQ-008 SHALL have ports: period_end  input  1  one-clk pulse from PWM core at end of each period.
REQ-009 SHALL have ports: spi_miso  output  1  serial readback data.
REQ-010 SHALL have ports: spi_miso_oe  output  1  MISO pad enable.
REQ-011 SHALL have ports: pwm_period  output  DATA_W  active period to PWM core.
REQ-012 SHALL have ports: pwm_duty  output  DATA_W  active duty to PWM core, clamped.
REQ-013 SHALL have ports: pwm_en  output  1  PWM enable.
REQ-014 SHALL have ports: cfg_pending  output  1  shadow differs from active, awaiting commit.

Function
REQ-015 SHALL pass sck, cs_n and mosi through SYNC_STAGES flops before use; sample mosi on synchronized sck rising edge, update miso on falling edge.
REQ-016 SHALL decode 16-bit frames: bit15 1=write/0=read, bits14:8 address, bits7:0 data.
REQ-017 SHALL implement FSM IDLE -> CMD (bits 0-7) -> DATA (bits 8-15) -> DONE (16 bits, await cs_n high) -> IDLE; any sck rising edge in DONE -> ERR; cs_n high in CMD/DATA/ERR -> IDLE with frame discarded.
REQ-018 SHALL apply a write only on cs_n rising edge from DONE; discarded frames set sticky frame_err.
REQ-019 SHALL map: 0x00 CTRL (bit0 enable, bit1 force_update, self-clearing), 0x01 PERIOD shadow, 0x02 DUTY shadow, 0x03 STATUS read-only (bit0 cfg_pending, bit1 frame_err); writes to other addresses ignored, reads return 0x00.
REQ-020 SHALL clear frame_err when STATUS is written with data bit1=1.
REQ-021 SHALL update the shadow register one clk after the synchronized cs_n rising edge; cfg_pending rises the same cycle if shadow differs from active.
REQ-022 SHALL copy shadow PERIOD/DUTY to active on period_end when cfg_pending=1, immediately when pwm_en=0, or immediately on force_update write.
REQ-023 SHALL, when period_end coincides with a shadow write, commit the pre-write shadow and keep cfg_pending=1 for the new value.
REQ-024 SHALL drive pwm_duty = min(active duty, active period); PERIOD=0 accepted and passed through.
REQ-025 SHALL update pwm_en from CTRL bit0 one clk after the write, independent of period_end.

Reset
REQ-026 SHALL on rst: pwm_period=all-ones, pwm_duty=0, pwm_en=0, cfg_pending=0, frame_err=0, spi_miso=0, spi_miso_oe=0, FSM=IDLE, shadows equal active.
REQ-027 SHALL ignore a frame in progress at reset release until cs_n is seen high.

Configuration
REQ-028 SHALL, with PWM_CFG_READBACK_EN defined, load addressed register after bit8 and shift it out on the next 8 sck falling edges, spi_miso_oe=1 while cs_n low.
REQ-029 SHALL, without PWM_CFG_READBACK_EN, hold spi_miso=0 and spi_miso_oe=0; read frames complete without error and have no effect.

Structure
REQ-030 SHALL place address constants, CTRL/STATUS bit indices, reset values and FSM state enum in package pwm_cfg_pkg.
REQ-031 SHALL use sub-module pwm_sync_edge (synchronizer plus rise/fall pulse) for sck and cs_n.

Verification
REQ-032 SHALL cover: write PERIOD=0x64 with pwm_en=0 -> pwm_period=0x64 within 4 clk of cs_n rise, cfg_pending stays 0.
REQ-033 SHALL cover: pwm_en=1, write DUTY=0x20 -> cfg_pending=1, pwm_duty unchanged until period_end, then 0x20 next clk.
REQ-034 SHALL cover: 15-bit frame then cs_n high -> no register change, STATUS read = 0x02; write STATUS 0x02 -> reads 0x00.
REQ-035 SHALL cover: PERIOD=0x10, DUTY=0x30 -> pwm_duty=0x10.
REQ-036 SHALL cover: write coincident with period_end -> old shadow committed, cfg_pending=1, new value on next period_end.
REQ-037 SHALL cover: with PWM_CFG_READBACK_EN, read 0x01 after PERIOD=0xA5 -> MISO bits 1010_0101.
